// File: rtl/booth_multiplier_nbit.sv
// booth_multiplier_nbit: sequential radix-2 Booth multiplier producing a 2N-bit signed product.
// One Booth iteration per clock with a start/done handshake.
module booth_multiplier_nbit #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t       state, state_next;
    logic [N:0]   a, m, sum;
    logic [N-1:0] q;
    logic         q_1;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = start ? S_RUN : S_IDLE;
            S_RUN:   state_next = (count == CW'(1)) ? S_DONE : S_RUN;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // A is one bit wider than the operands so the most-negative M cannot overflow
    always_comb begin
        sum = (q[0] & ~q_1) ? a - m : (~q[0] & q_1) ? a + m : a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= '0;
            m       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_IDLE && start) begin
                a     <= '0;
                m     <= {multiplicand[N-1], multiplicand};
                q     <= multiplier;
                q_1   <= 1'b0;
                count <= CW'(N);
            end else if (state == S_RUN) begin
                a     <= {sum[N], sum[N:1]};
                q     <= {sum[0], q[N-1:1]};
                q_1   <= q[0];
                count <= count - CW'(1);
            end
            if (state == S_DONE) product <= {a[N-1:0], q};
        end
    end
endmodule

// File: tb/tb_booth_multiplier_nbit.sv
// tb_booth_multiplier_nbit: checks the Booth multiplier at N = 4, 8, 16, 32 against
// plain signed multiplication of sign-extended operands.
module tb_booth_multiplier_nbit;
    logic              clk;
    logic              rst;
    logic [3:0]        start_v;
    logic [31:0]       mc;
    logic [31:0]       mq;
    logic [3:0]        busy_v;
    logic [3:0]        done_v;
    logic signed [63:0] prod [4];
    int checks = 0;
    int errors = 0;

    genvar g;
    for (g = 0; g < 4; g++) begin : gen_dut
        localparam int W = 4 << g;
        logic [2*W-1:0] p;
        booth_multiplier_nbit #(.N(W)) u_dut (
            .clk(clk),
            .rst(rst),
            .start(start_v[g]),
            .multiplicand(mc[W-1:0]),
            .multiplier(mq[W-1:0]),
            .busy(busy_v[g]),
            .done(done_v[g]),
            .product(p)
        );
        assign prod[g] = 64'($signed(p));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        return (v << (64 - w)) >>> (64 - w);
    endfunction

    task automatic run(input int idx, input longint m, input longint q);
        int w;
        int lat;
        w = 4 << idx;
        @(negedge clk);
        mc = m[31:0];
        mq = q[31:0];
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        lat = 0;
        while (!done_v[idx] && lat < 4 * w + 10) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency N=%0d", w), lat, w + 1);
        check($sformatf("product N=%0d %0d*%0d", w, sx(m, w), sx(q, w)), prod[idx], sx(m, w) * sx(q, w));
        @(negedge clk);
        check($sformatf("done pulse N=%0d", w), done_v[idx], 0);
    endtask

    initial begin
        int lat;
        int pulses;
        rst = 1'b1;
        start_v = '0;
        mc = '0;
        mq = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy_v, 0);
        check("reset done", done_v, 0);
        check("reset product N=4", prod[0], 0);
        check("reset product N=32", prod[3], 0);
        rst = 1'b0;

        run(0, -3, 5);
        check("N=4 -3*5", prod[0], -15);
        run(1, 12, -5);
        check("N=8 12*-5", prod[1], -60);
        run(2, -300, 250);
        check("N=16 -300*250", prod[2], -75000);
        run(3, 100000, -200000);
        check("N=32 100000*-200000", prod[3], -64'sd20000000000);

        run(0, -8, -8);
        check("N=4 -8*-8", prod[0], 64);
        run(0, -8, 7);
        check("N=4 -8*7", prod[0], -56);
        run(0, 0, -8);
        check("N=4 0*-8", prod[0], 0);
        run(0, 7, 7);
        check("N=4 7*7", prod[0], 49);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run(0, longint'(i), longint'(j));

        for (int k = 0; k < 30; k++) begin
            run(1, longint'($urandom), longint'($urandom));
            run(2, longint'($urandom), longint'($urandom));
            run(3, longint'($urandom), longint'($urandom));
        end

        // start and operand changes while busy must not disturb the running multiply
        @(negedge clk);
        mc = 32'd3;
        mq = 32'hE;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        mc = 32'd7;
        mq = 32'd7;
        start_v[0] = 1'b1;
        lat = 0;
        @(negedge clk);
        lat++;
        check("busy mid-run", busy_v[0], 1);
        @(negedge clk);
        lat++;
        start_v[0] = 1'b0;
        while (!done_v[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ignored start latency", lat, 5);
        check("ignored start product", prod[0], -6);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0]) pulses++;
        end
        check("ignored start extra done", pulses, 0);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        mc = 32'd5;
        mq = 32'd3;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", busy_v[0], 0);
        check("async rst done", done_v[0], 0);
        check("async rst product", prod[0], 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0]) pulses++;
        end
        check("aborted run done", pulses, 0);
        run(0, 5, 3);
        check("after reset 5*3", prod[0], 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
